// File: rtl/complex_divider.sv
// Fixed-point complex divider computing a/b = a*conj(b)/|b|^2 with a restoring divider.
// Fixed latency; the real and imaginary quotients run in parallel against one shared divisor.
module complex_divider #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] a_real,
    input  logic signed [DATA_WIDTH-1:0] a_imag,
    input  logic signed [DATA_WIDTH-1:0] b_real,
    input  logic signed [DATA_WIDTH-1:0] b_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_real,
    output logic signed [DATA_WIDTH-1:0] out_imag,
    output logic                         div_zero,
    output logic                         sat
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned NUM_W = 2 * W + 1;
    localparam int unsigned MAG_W = 2 * W;
    localparam int unsigned REM_W = MAG_W + FRAC;
    localparam int unsigned SH_W  = MAG_W + W;
    localparam int unsigned CMP_W = (REM_W > SH_W) ? REM_W : SH_W;
    localparam int unsigned CNT_W = $clog2(W + 1);

    localparam logic [W-1:0]     MAX_MAG = {1'b0, {(W - 1){1'b1}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        DIV,
        DONE
    } state_t;

    state_t state, state_next;

    logic signed [W-1:0] ar_q, ai_q, br_q, bi_q;
    logic                neg_re, neg_im, ovf_re, ovf_im, dz;
    logic [REM_W-1:0]    rem_re, rem_im;
    logic [SH_W-1:0]     dsh;
    logic [W-1:0]        q_re, q_im;
    logic [CNT_W-1:0]    cnt;

    // Full-precision numerators, divisor energy and magnitudes from the captured operands
    logic signed [NUM_W-1:0] num_re, num_im;
    logic [MAG_W-1:0]        mag_re, mag_im, den;
    logic                    pre_ovf_re, pre_ovf_im;

    always_comb begin
        num_re     = NUM_W'(ar_q) * NUM_W'(br_q) + NUM_W'(ai_q) * NUM_W'(bi_q);
        num_im     = NUM_W'(ai_q) * NUM_W'(br_q) - NUM_W'(ar_q) * NUM_W'(bi_q);
        den        = MAG_W'(NUM_W'(br_q) * NUM_W'(br_q) + NUM_W'(bi_q) * NUM_W'(bi_q));
        mag_re     = MAG_W'(num_re[NUM_W-1] ? -num_re : num_re);
        mag_im     = MAG_W'(num_im[NUM_W-1] ? -num_im : num_im);
        // A quotient needing more than W bits can never fit after clamping
        pre_ovf_re = (CMP_W'(mag_re) << FRAC) >= (CMP_W'(den) << W);
        pre_ovf_im = (CMP_W'(mag_im) << FRAC) >= (CMP_W'(den) << W);
    end

    // One restoring step per component, plus the clamped signed result
    logic                ge_re, ge_im, sat_re, sat_im;
    logic [REM_W-1:0]    rem_re_n, rem_im_n;
    logic [W-1:0]        q_re_n, q_im_n, mag_out_re, mag_out_im;
    logic signed [W-1:0] res_re, res_im;

    always_comb begin
        ge_re      = CMP_W'(rem_re) >= CMP_W'(dsh);
        ge_im      = CMP_W'(rem_im) >= CMP_W'(dsh);
        rem_re_n   = ge_re ? rem_re - REM_W'(dsh) : rem_re;
        rem_im_n   = ge_im ? rem_im - REM_W'(dsh) : rem_im;
        q_re_n     = {q_re[W-2:0], ge_re};
        q_im_n     = {q_im[W-2:0], ge_im};
        sat_re     = ovf_re || (q_re_n > MAX_MAG);
        sat_im     = ovf_im || (q_im_n > MAX_MAG);
        mag_out_re = sat_re ? MAX_MAG : q_re_n;
        mag_out_im = sat_im ? MAX_MAG : q_im_n;
        res_re     = neg_re ? -$signed(mag_out_re) : $signed(mag_out_re);
        res_im     = neg_im ? -$signed(mag_out_im) : $signed(mag_out_im);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid && in_ready) state_next = PREP;
            PREP:    state_next = DIV;
            DIV:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q     <= '0;
            ai_q     <= '0;
            br_q     <= '0;
            bi_q     <= '0;
            neg_re   <= 1'b0;
            neg_im   <= 1'b0;
            ovf_re   <= 1'b0;
            ovf_im   <= 1'b0;
            dz       <= 1'b0;
            rem_re   <= '0;
            rem_im   <= '0;
            dsh      <= '0;
            q_re     <= '0;
            q_im     <= '0;
            cnt      <= '0;
            out_real <= '0;
            out_imag <= '0;
            div_zero <= 1'b0;
            sat      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        ar_q <= a_real;
                        ai_q <= a_imag;
                        br_q <= b_real;
                        bi_q <= b_imag;
                    end
                end
                PREP: begin
                    neg_re <= num_re[NUM_W-1];
                    neg_im <= num_im[NUM_W-1];
                    ovf_re <= pre_ovf_re;
                    ovf_im <= pre_ovf_im;
                    dz     <= (den == '0);
                    rem_re <= REM_W'(mag_re) << FRAC;
                    rem_im <= REM_W'(mag_im) << FRAC;
                    dsh    <= SH_W'(den) << (W - 1);
                    q_re   <= '0;
                    q_im   <= '0;
                    cnt    <= '0;
                end
                DIV: begin
                    rem_re <= rem_re_n;
                    rem_im <= rem_im_n;
                    q_re   <= q_re_n;
                    q_im   <= q_im_n;
                    dsh    <= dsh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Results land together with the final quotient bit
                    if (cnt == LAST) begin
                        out_real <= dz ? '0 : res_re;
                        out_imag <= dz ? '0 : res_im;
                        div_zero <= dz;
                        sat      <= !dz && (sat_re || sat_im);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_complex_divider.sv
// Bench for complex_divider: directed vector table, handshake/reset sequences and a
// randomized sweep over parallel instances checked against an arithmetic reference model.
module tb_complex_divider;

    localparam int     DW       = 16;
    localparam int     FR       = 8;
    localparam int     LANES    = 5;
    localparam int     LAT      = DW + 2;
    localparam int     RAND_OPS = 10000;
    localparam longint MAXV     = (longint'(1) << (DW - 1)) - 1;

    logic clk = 1'b0;
    logic rst;

    logic                 in_valid  [LANES];
    logic                 in_ready  [LANES];
    logic signed [DW-1:0] a_real    [LANES];
    logic signed [DW-1:0] a_imag    [LANES];
    logic signed [DW-1:0] b_real    [LANES];
    logic signed [DW-1:0] b_imag    [LANES];
    logic                 out_valid [LANES];
    logic                 out_ready [LANES];
    logic signed [DW-1:0] out_real  [LANES];
    logic signed [DW-1:0] out_imag  [LANES];
    logic                 div_zero  [LANES];
    logic                 sat       [LANES];

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        complex_divider #(.DATA_WIDTH(DW), .FRAC(FR)) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a_real   (a_real[g]),
            .a_imag   (a_imag[g]),
            .b_real   (b_real[g]),
            .b_imag   (b_imag[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_real (out_real[g]),
            .out_imag (out_imag[g]),
            .div_zero (div_zero[g]),
            .sat      (sat[g])
        );
    end

    typedef struct {
        int ar, ai, br, bi;
        int er, ei;
        bit dz, st;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact complex quotient, truncated toward zero, symmetric clamp
    function automatic longint quot(input longint n, input longint d);
        longint m;
        m = (n < 0) ? -n : n;
        return (m * (longint'(1) << FR)) / d;
    endfunction

    function automatic void model(input int ar, input int ai, input int br, input int bi,
                                  output int er, output int ei, output bit dz, output bit st);
        longint nr, ni, den, qr, qi;
        nr  = longint'(ar) * longint'(br) + longint'(ai) * longint'(bi);
        ni  = longint'(ai) * longint'(br) - longint'(ar) * longint'(bi);
        den = longint'(br) * longint'(br) + longint'(bi) * longint'(bi);
        er  = 0;
        ei  = 0;
        st  = 1'b0;
        dz  = (den == 0);
        if (!dz) begin
            qr = quot(nr, den);
            qi = quot(ni, den);
            if (qr > MAXV) begin qr = MAXV; st = 1'b1; end
            if (qi > MAXV) begin qi = MAXV; st = 1'b1; end
            er = int'((nr < 0) ? -qr : qr);
            ei = int'((ni < 0) ? -qi : qi);
        end
    endfunction

    function automatic int rnd16(input int mode);
        logic signed [DW-1:0] t;
        case (mode)
            0: t = DW'($urandom);
            1: t = DW'(int'($urandom_range(0, 64)) - 32);
            2: begin
                case ($urandom_range(0, 5))
                    0:       t = DW'(-32768);
                    1:       t = DW'(-32767);
                    2:       t = DW'(-1);
                    3:       t = DW'(0);
                    4:       t = DW'(1);
                    default: t = DW'(32767);
                endcase
            end
            default: t = '0;
        endcase
        return int'(t);
    endfunction

    // Starts and ends on a falling edge; hold = cycles out_ready stays low once out_valid rises
    task automatic do_op(input int ln, input int ar, input int ai, input int br, input int bi,
                         input int hold, output int rr, output int ri, output bit dz,
                         output bit st, output int lat);
        int n;
        int t0;
        in_valid[ln]  = 1'b1;
        a_real[ln]    = DW'(ar);
        a_imag[ln]    = DW'(ai);
        b_real[ln]    = DW'(br);
        b_imag[ln]    = DW'(bi);
        out_ready[ln] = (hold == 0);
        n = 0;
        while (!in_ready[ln] && n < 40) begin @(negedge clk); n++; end
        chk("accept in_ready", longint'(in_ready[ln]), 1);
        t0 = cyc;
        @(posedge clk);
        @(negedge clk);
        in_valid[ln] = 1'b0;
        a_real[ln]   = DW'($urandom);
        a_imag[ln]   = DW'($urandom);
        b_real[ln]   = DW'($urandom);
        b_imag[ln]   = DW'($urandom);
        n = 0;
        while (!out_valid[ln] && n < 4 * LAT) begin @(negedge clk); n++; end
        lat = out_valid[ln] ? cyc - t0 : -1;
        rr  = int'(out_real[ln]);
        ri  = int'(out_imag[ln]);
        dz  = div_zero[ln];
        st  = sat[ln];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("backpressure hold stable",
                (out_valid[ln] && !in_ready[ln] && int'(out_real[ln]) == rr &&
                 int'(out_imag[ln]) == ri && div_zero[ln] == dz && sat[ln] == st) ? 1 : 0, 1);
        end
        out_ready[ln] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("handoff {in_ready,out_valid}", longint'({in_ready[ln], out_valid[ln]}), 2);
    endtask

    task automatic sweep(input int ln, input int nops);
        int ar, ai, br, bi, er, ei, rr, ri, lat, mb;
        bit edz, est, dz, st;
        for (int i = 0; i < nops; i++) begin
            ar = rnd16(($urandom_range(0, 9) < 7) ? 0 : 2);
            ai = rnd16(($urandom_range(0, 9) < 7) ? 0 : 1);
            mb = int'($urandom_range(0, 9));
            if (mb == 9) begin
                br = 0;
                bi = 0;
            end else begin
                br = rnd16((mb < 5) ? 0 : (mb < 8) ? 1 : 2);
                bi = rnd16((mb < 5) ? 0 : (mb < 8) ? 1 : 2);
            end
            model(ar, ai, br, bi, er, ei, edz, est);
            do_op(ln, ar, ai, br, bi, 0, rr, ri, dz, st, lat);
            chk($sformatf("rand re (%0d,%0d)/(%0d,%0d)", ar, ai, br, bi), rr, er);
            chk($sformatf("rand im (%0d,%0d)/(%0d,%0d)", ar, ai, br, bi), ri, ei);
            chk($sformatf("rand div_zero (%0d,%0d)/(%0d,%0d)", ar, ai, br, bi), dz, edz);
            chk($sformatf("rand sat (%0d,%0d)/(%0d,%0d)", ar, ai, br, bi), st, est);
            chk("rand latency", lat, LAT);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  rr, ri, lat, t0, n;
        bit  dz, st, seen;

        vecs[0]  = '{512, 256, 256, 0, 512, 256, 1'b0, 1'b0};
        vecs[1]  = '{256, 0, 0, 256, 0, -256, 1'b0, 1'b0};
        vecs[2]  = '{256, 256, 256, 256, 256, 0, 1'b0, 1'b0};
        vecs[3]  = '{-1, 0, 512, 0, 0, 0, 1'b0, 1'b0};
        vecs[4]  = '{32767, 0, 1, 0, 32767, 0, 1'b0, 1'b1};
        vecs[5]  = '{-32768, 0, 1, 0, -32767, 0, 1'b0, 1'b1};
        vecs[6]  = '{1234, -77, 0, 0, 0, 0, 1'b1, 1'b0};
        vecs[7]  = '{0, 0, 300, -5, 0, 0, 1'b0, 1'b0};
        vecs[8]  = '{127, -128, 1, 0, 32512, -32767, 1'b0, 1'b1};
        vecs[9]  = '{127, -127, 1, 0, 32512, -32512, 1'b0, 1'b0};
        vecs[10] = '{-300, 7, 3, -4, -9502, -12072, 1'b0, 1'b0};
        vecs[11] = '{32767, 32767, 0, 1, 32767, -32767, 1'b0, 1'b1};
        vecs[12] = '{-32768, -32768, -32768, -32768, 256, 0, 1'b0, 1'b0};

        rst = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b1;
            a_real[k]    = '0;
            a_imag[k]    = '0;
            b_real[k]    = '0;
            b_imag[k]    = '0;
        end
        repeat (3) @(negedge clk);
        chk("reset {in_ready,out_valid,div_zero,sat}",
            longint'({in_ready[0], out_valid[0], div_zero[0], sat[0]}), 8);
        chk("reset out_real", out_real[0], 0);
        chk("reset out_imag", out_imag[0], 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            do_op(0, vecs[i].ar, vecs[i].ai, vecs[i].br, vecs[i].bi, 0, rr, ri, dz, st, lat);
            chk($sformatf("vec%0d re", i), rr, vecs[i].er);
            chk($sformatf("vec%0d im", i), ri, vecs[i].ei);
            chk($sformatf("vec%0d div_zero", i), dz, vecs[i].dz);
            chk($sformatf("vec%0d sat", i), st, vecs[i].st);
            chk($sformatf("vec%0d latency", i), lat, LAT);
        end

        // Backpressure: result held for 10 cycles before the consumer takes it
        do_op(0, 512, 256, 256, 0, 10, rr, ri, dz, st, lat);
        chk("backpressure re", rr, 512);
        chk("backpressure im", ri, 256);
        chk("backpressure latency", lat, LAT);

        // Reset pulsed in DIV cycle 5 aborts the operation silently
        in_valid[0] = 1'b1;
        a_real[0]   = 16'sd512;
        a_imag[0]   = 16'sd256;
        b_real[0]   = 16'sd256;
        b_imag[0]   = 16'sd0;
        t0 = cyc;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        while (cyc < t0 + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort in_ready", longint'(in_ready[0]), 1);
        seen = 1'b0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        chk("aborted op never valid", seen, 0);
        do_op(0, 512, 256, 256, 0, 0, rr, ri, dz, st, lat);
        chk("post-abort re", rr, 512);
        chk("post-abort im", ri, 256);
        chk("post-abort latency", lat, LAT);

        // Accept on the very first clock after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 256, 256, 256, 256, 0, rr, ri, dz, st, lat);
        chk("first-clock re", rr, 256);
        chk("first-clock im", ri, 0);
        chk("first-clock latency", lat, LAT);

        // Asynchronous reset while a result waits for the consumer
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        a_real[0]    = 16'sd256;
        a_imag[0]    = 16'sd0;
        b_real[0]    = 16'sd0;
        b_imag[0]    = 16'sd256;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 4 * LAT) begin @(negedge clk); n++; end
        chk("pending out_valid", longint'(out_valid[0]), 1);
        chk("pending out_imag", out_imag[0], -256);
        #2 rst = 1'b1;
        #1;
        chk("async reset {out_valid,in_ready,re!=0,im!=0,div_zero,sat}",
            longint'({out_valid[0], in_ready[0], out_real[0] != 0, out_imag[0] != 0,
                      div_zero[0], sat[0]}), 16);
        @(negedge clk);
        rst = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);

        fork
            sweep(0, RAND_OPS / LANES);
            sweep(1, RAND_OPS / LANES);
            sweep(2, RAND_OPS / LANES);
            sweep(3, RAND_OPS / LANES);
            sweep(4, RAND_OPS / LANES);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
